// File: rtl/ibex_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ibex_mem_arbiter_pkg
//
// Shared types for the instruction/data memory arbiter.
//   mem_host_e : identifies which host a transaction belongs to. Used for the
//                arbiter's request lock and for every entry of the ID FIFO.
// ----------------------------------------------------------------------------
package ibex_mem_arbiter_pkg;

    typedef enum logic {
        MemHostInstr = 1'b0,
        MemHostData  = 1'b1
    } mem_host_e;

    // Byte enable presented for instruction fetches (always full words).
    localparam logic [3:0] MemBeAll = 4'hF;

endpackage

// File: rtl/ibex_mem_arb_id_fifo.sv
// ----------------------------------------------------------------------------
// ibex_mem_arb_id_fifo
//
// In-order FIFO of host IDs for granted-but-unanswered memory transactions.
// The head entry tells the arbiter which host an incoming rvalid belongs to.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (empties the FIFO)
//   push_i          push push_id_i (ignored while full)
//   push_id_i       host ID of the transaction just granted
//   pop_i           pop the head entry (ignored while empty)
//   pop_id_o        host ID at the head (undefined while empty)
//   full_o/empty_o  occupancy flags
//   count_o         number of valid entries, 0..Depth
// ----------------------------------------------------------------------------
module ibex_mem_arb_id_fifo
    import ibex_mem_arbiter_pkg::*;
#(
    parameter  int unsigned Depth = 2,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  mem_host_e       push_id_i,
    input  logic            pop_i,
    output mem_host_e       pop_id_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    mem_host_e            ids_q [Depth];
    logic      [PtrW-1:0] wptr_q;
    logic      [PtrW-1:0] rptr_q;
    logic      [CntW-1:0] count_q;
    logic                 do_push;
    logic                 do_pop;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o   = (count_q == CntW'(Depth));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign pop_id_o = ids_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage carries no reset; validity is defined by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) ids_q[wptr_q] <= push_id_i;
    end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ibex_mem_arbiter
//
// Shares one memory port between the Ibex instruction-fetch and LSU hosts on
// the req/gnt/rvalid protocol. A request that is presented but not yet granted
// is locked to its host until mem_gnt_i. Granted transactions are tracked in
// order so each rvalid is steered back to the host that issued it; rdata/err
// are broadcast to both hosts.
//
// Build option:
//   IBEX_MEM_ARB_RR_EN  defined   : round-robin on conflicts (host not granted
//                                   last wins; data wins the first conflict)
//                       undefined : fixed priority, data wins conflicts
//
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   instr_req_i/gnt_o/rvalid_o           fetch handshake
//   instr_addr_i                         fetch address
//   instr_rdata_o/err_o                  fetch response
//   data_req_i/gnt_o/rvalid_o            LSU handshake
//   data_we_i/be_i/addr_i/wdata_i        LSU request
//   data_rdata_o/err_o                   LSU response
//   mem_req_o/gnt_i/rvalid_i             device handshake
//   mem_we_o/be_o/addr_o/wdata_o         device request
//   mem_rdata_i/err_i                    device response
// ----------------------------------------------------------------------------
module ibex_mem_arbiter
    import ibex_mem_arbiter_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    mem_host_e            sel;
    mem_host_e            conflict_winner;
    mem_host_e            head_id;
    mem_host_e            lock_host_q;
    logic                 lock_valid_q;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CntW-1:0]      fifo_count;

`ifdef IBEX_MEM_ARB_RR_EN
    mem_host_e last_q;

    // Resets to "fetch last granted" so the first conflict goes to data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= MemHostInstr;
        end else if (push) begin
            last_q <= sel;
        end
    end

    assign conflict_winner = (last_q == MemHostData) ? MemHostInstr : MemHostData;
`else
    assign conflict_winner = MemHostData;
`endif

    // Host selection: a held lock always wins, then conflict resolution.
    always_comb begin
        sel = MemHostInstr;
        if (lock_valid_q) begin
            sel = lock_host_q;
        end else if (instr_req_i && data_req_i) begin
            sel = conflict_winner;
        end else if (data_req_i) begin
            sel = MemHostData;
        end
    end

    // A full FIFO blocks new requests; a same-cycle pop does not lift this,
    // which keeps mem_rvalid_i out of the mem_req_o cone.
    assign mem_req_o = (instr_req_i | data_req_i) & ~fifo_full;
    assign push      = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & ~fifo_empty;

    assign instr_gnt_o = push & (sel == MemHostInstr);
    assign data_gnt_o  = push & (sel == MemHostData);

    // Responses with no outstanding entry are dropped (pop is gated).
    assign instr_rvalid_o = pop & (head_id == MemHostInstr);
    assign data_rvalid_o  = pop & (head_id == MemHostData);

    assign instr_rdata_o = mem_rdata_i;
    assign instr_err_o   = mem_err_i;
    assign data_rdata_o  = mem_rdata_i;
    assign data_err_o    = mem_err_i;

    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = MemBeAll;
        mem_wdata_o = '0;
        if (sel == MemHostData) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    // The lock is re-evaluated every cycle: it holds exactly while a request
    // is presented and not granted, so it clears on grant or when full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_valid_q <= 1'b0;
            lock_host_q  <= MemHostInstr;
        end else begin
            lock_valid_q <= mem_req_o & ~mem_gnt_i;
            lock_host_q  <= sel;
        end
    end

    ibex_mem_arb_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push),
        .push_id_i (sel),
        .pop_i     (pop),
        .pop_id_o  (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(mem_rvalid_i && fifo_empty))
                else $warning("ibex_mem_arbiter: rvalid with no outstanding transaction, response dropped");
            assert (fifo_count <= CntW'(MaxOutstanding))
                else $error("ibex_mem_arbiter: outstanding count exceeds limit");
        end
    end
`endif

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
module tb_ibex_mem_arbiter;

    localparam int MAX   = 2;
    localparam int INSTR = 0;
    localparam int DATA  = 1;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_i = 1'b0;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_addr_i = '0;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;

    ibex_mem_arbiter #(.MaxOutstanding(MAX)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of host IDs awaiting a response, the host
    // holding an ungranted request (-1 none), and the last granted host.
    int q[$];
    int pending = -1;
    int last_g  = INSTR;

    // Expectations for the current cycle, used by clock_model().
    bit e_req;
    int e_sel;
    bit e_pop;
    bit i_granted;
    bit d_granted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int conflict_pick();
`ifdef IBEX_MEM_ARB_RR_EN
        return (last_g == DATA) ? INSTR : DATA;
`else
        return DATA;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        pending = -1;
        last_g  = INSTR;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic settle_check();
        int head;
        #1;
        e_req = (instr_req_i || data_req_i) && (q.size() < MAX);
        if (pending >= 0)                    e_sel = pending;
        else if (instr_req_i && data_req_i)  e_sel = conflict_pick();
        else                                 e_sel = data_req_i ? DATA : INSTR;
        e_pop = mem_rvalid_i && (q.size() > 0);
        head  = e_pop ? q[0] : -1;

        chk("mem_req",      mem_req_o,      e_req);
        chk("instr_gnt",    instr_gnt_o,    e_req && mem_gnt_i && e_sel == INSTR);
        chk("data_gnt",     data_gnt_o,     e_req && mem_gnt_i && e_sel == DATA);
        chk("instr_rvalid", instr_rvalid_o, head == INSTR);
        chk("data_rvalid",  data_rvalid_o,  head == DATA);
        chk("instr_rdata",  instr_rdata_o,  mem_rdata_i);
        chk("data_rdata",   data_rdata_o,   mem_rdata_i);
        chk("instr_err",    instr_err_o,    mem_err_i);
        chk("data_err",     data_err_o,     mem_err_i);
        if (e_req) begin
            if (e_sel == DATA) begin
                chk("addr_d",  mem_addr_o,  data_addr_i);
                chk("we_d",    mem_we_o,    data_we_i);
                chk("be_d",    mem_be_o,    data_be_i);
                chk("wdata_d", mem_wdata_o, data_wdata_i);
            end else begin
                chk("addr_i",  mem_addr_o,  instr_addr_i);
                chk("we_i",    mem_we_o,    1'b0);
                chk("be_i",    mem_be_o,    4'hF);
                chk("wdata_i", mem_wdata_o, 32'h0);
            end
        end
    endtask

    task automatic clock_model();
        @(posedge clk_i);
        i_granted = 1'b0;
        d_granted = 1'b0;
        if (rst_ni) begin
            if (e_pop) void'(q.pop_front());
            if (e_req && mem_gnt_i) begin
                q.push_back(e_sel);
                last_g    = e_sel;
                i_granted = (e_sel == INSTR);
                d_granted = (e_sel == DATA);
            end
            pending = (e_req && !mem_gnt_i) ? e_sel : -1;
        end else begin
            pending = -1;
        end
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        data_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_reset();
        settle_check();
        chk("rst_instr_rvalid", instr_rvalid_o, 1'b0);
        chk("rst_data_rvalid",  data_rvalid_o,  1'b0);
        clock_model();
        rst_ni = 1'b1;
    endtask

    int exp_seq [4];

    initial begin
        // Reset state: rvalid driven during reset must not reach a host.
        @(negedge clk_i);
        idle_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_2222;
        do_reset();
        chk("rst_mem_req", mem_req_o, 1'b0);
        mem_rvalid_i = 1'b0;

        // Fetch-only at 0x80 with immediate grant, response next cycle.
        instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
        settle_check();
        chk("t1_instr_gnt", instr_gnt_o, 1'b1);
        chk("t1_addr", mem_addr_o, 32'h80);
        clock_model();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        settle_check();
        chk("t1_instr_rvalid", instr_rvalid_o, 1'b1);
        chk("t1_rdata", instr_rdata_o, 32'hDEAD_BEEF);
        chk("t1_data_rvalid", data_rvalid_o, 1'b0);
        clock_model();
        mem_rvalid_i = 1'b0;

        // Conflict with grant withheld 3 cycles while fetch req toggles.
        data_req_i = 1'b1; data_addr_i = 32'hA000_0000; data_we_i = 1'b0;
        data_be_i = 4'h3; data_wdata_i = 32'h0;
        instr_req_i = 1'b1; instr_addr_i = 32'h84;
        for (int c = 0; c < 3; c++) begin
            instr_req_i = (c != 1);
            settle_check();
            chk("t2_hold_addr", mem_addr_o, 32'hA000_0000);
            clock_model();
        end
        instr_req_i = 1'b1; mem_gnt_i = 1'b1;
        settle_check();
        chk("t2_data_gnt", data_gnt_o, 1'b1);
        chk("t2_instr_gnt", instr_gnt_o, 1'b0);
        clock_model();
        data_req_i = 1'b0;
        settle_check();
        chk("t2_fetch_next", instr_gnt_o, 1'b1);
        chk("t2_fetch_addr", mem_addr_o, 32'h84);
        clock_model();
        idle_inputs();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0001;
        settle_check();
        chk("t2_resp_data", data_rvalid_o, 1'b1);
        clock_model();
        mem_rdata_i = 32'h0000_0002;
        settle_check();
        chk("t2_resp_instr", instr_rvalid_o, 1'b1);
        clock_model();
        idle_inputs();

        // Full FIFO: two grants, then requests blocked until a response.
        instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
        settle_check();
        clock_model();
        instr_req_i = 1'b0;
        data_req_i = 1'b1; data_addr_i = 32'h200; data_we_i = 1'b1;
        data_be_i = 4'h5; data_wdata_i = 32'h55AA_55AA;
        settle_check();
        chk("t3_data_we", mem_we_o, 1'b1);
        clock_model();
        instr_req_i = 1'b1; instr_addr_i = 32'h104; data_addr_i = 32'h204;
        settle_check();
        chk("t3_full_req", mem_req_o, 1'b0);
        chk("t3_full_gnt", instr_gnt_o | data_gnt_o, 1'b0);
        clock_model();
        mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'h0000_1234;
        settle_check();
        chk("t3_err_rvalid", instr_rvalid_o, 1'b1);
        chk("t3_err", instr_err_o, 1'b1);
        chk("t3_no_pop_push", mem_req_o, 1'b0);
        clock_model();
        mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_gnt_i = 1'b0;
        settle_check();
        chk("t3_req_back", mem_req_o, 1'b1);
        clock_model();
        idle_inputs();
        mem_rvalid_i = 1'b1;
        settle_check();
        chk("t3_drain", data_rvalid_o, 1'b1);
        clock_model();
        idle_inputs();
        settle_check();
        clock_model();

        // Continuous conflict with grant and response every cycle.
        do_reset();
`ifdef IBEX_MEM_ARB_RR_EN
        exp_seq = '{DATA, INSTR, DATA, INSTR};
`else
        exp_seq = '{DATA, DATA, DATA, DATA};
`endif
        instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
        data_we_i = 1'b0; data_be_i = 4'hF;
        for (int c = 0; c < 4; c++) begin
            instr_addr_i = 32'h400 + 32'(c * 4);
            data_addr_i  = 32'h800 + 32'(c * 4);
            mem_rvalid_i = (c != 0);
            settle_check();
            chk("t4_seq_data_gnt", data_gnt_o, exp_seq[c] == DATA);
            chk("t4_seq_instr_gnt", instr_gnt_o, exp_seq[c] == INSTR);
            clock_model();
        end
        idle_inputs();
        mem_rvalid_i = 1'b1;
        settle_check();
        clock_model();
        idle_inputs();

        // Reset with a fetch outstanding; late response must be dropped.
        instr_req_i = 1'b1; instr_addr_i = 32'h300; mem_gnt_i = 1'b1;
        settle_check();
        clock_model();
        idle_inputs();
        do_reset();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        settle_check();
        chk("t5_drop_instr", instr_rvalid_o, 1'b0);
        chk("t5_drop_data", data_rvalid_o, 1'b0);
        clock_model();
        idle_inputs();
        instr_req_i = 1'b1; instr_addr_i = 32'h304; mem_gnt_i = 1'b1;
        settle_check();
        chk("t5_refetch_gnt", instr_gnt_o, 1'b1);
        clock_model();
        idle_inputs();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h600D_600D;
        settle_check();
        chk("t5_refetch_rvalid", instr_rvalid_o, 1'b1);
        clock_model();
        idle_inputs();

        // Randomized traffic; hosts hold requests until granted.
        for (int c = 0; c < 400; c++) begin
            if (!instr_req_i || i_granted) begin
                instr_req_i  = 1'($urandom_range(0, 1));
                instr_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!data_req_i || d_granted) begin
                data_req_i   = 1'($urandom_range(0, 1));
                data_addr_i  = $urandom;
                data_we_i    = 1'($urandom_range(0, 1));
                data_be_i    = 4'($urandom_range(0, 15));
                data_wdata_i = $urandom;
            end
            mem_gnt_i    = 1'($urandom_range(0, 1));
            mem_rvalid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i  = $urandom;
            mem_err_i    = 1'($urandom_range(0, 1));
            settle_check();
            clock_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
